// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// instruction field values and datapath select codes.
package ctrl_pkg;

  // Seventeen states need a 5-bit code; HALT keeps 4'hF and LUI_WB takes the next free code.
  typedef enum logic [4:0] {
    RST     = 5'h00,
    FETCH   = 5'h01,
    DECODE  = 5'h02,
    R_EXEC  = 5'h03,
    R_WB    = 5'h04,
    I_EXEC  = 5'h05,
    I_WB    = 5'h06,
    LD_ADDR = 5'h07,
    LD_MEM  = 5'h08,
    LD_MDR  = 5'h09,
    LD_WB   = 5'h0A,
    SD_ADDR = 5'h0B,
    SD_MEM  = 5'h0C,
    BRANCH  = 5'h0D,
    PC_INC  = 5'h0E,
    HALT    = 5'h0F,
    LUI_WB  = 5'h10
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_SD  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_IMM    = 2'b10;

  // States whose exit edge also advances PC by 4 and retires the instruction.
  function automatic logic isSeqRetire(input state_t s);
    return (s == R_WB) || (s == I_WB) || (s == LD_WB) || (s == LUI_WB) ||
           (s == SD_MEM) || (s == PC_INC);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Instruction dispatch: maps opcode/funct3/funct7 to the state that follows
// DECODE, and gives the ALU operation for register-register instructions.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output state_t     nextState,
  output logic [2:0] rFunct
);

  always_comb begin
    nextState = HALT;
    rFunct    = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        if (funct7 == F7_BASE && funct3 == F3_ADD) begin
          nextState = R_EXEC;
          rFunct    = ALU_ADD;
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          nextState = R_EXEC;
          rFunct    = ALU_SUB;
        end else if (funct7 == F7_BASE && funct3 == F3_AND) begin
          nextState = R_EXEC;
          rFunct    = ALU_AND;
        end
      end
      OP_IMM:    if (funct3 == F3_ADD) nextState = I_EXEC;
      OP_LOAD:   if (funct3 == F3_LD) nextState = LD_ADDR;
      OP_STORE:  if (funct3 == F3_SD) nextState = SD_ADDR;
      OP_BRANCH: if (funct3 == F3_BEQ || funct3 == F3_BNE) nextState = BRANCH;
      OP_LUI:    nextState = LUI_WB;
      default:   nextState = HALT;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle Moore control FSM for the 64-bit RISC-V datapath: sequences
// fetch/decode/execute/writeback and counts retired instructions.
module unidade_controle
  import ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [31:0]          inst,
  input  logic                 zero,
  output logic                 PCSrc,
  output logic [2:0]           ALUFunct,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 BranchOp,
  output logic                 LoadRegA,
  output logic                 LoadRegB,
  output logic                 LoadALUOut,
  output logic                 LoadIR,
  output logic                 LoadMDR,
  output logic                 WriteReg,
  output logic                 IMemWrite,
  output logic                 DMemWrite,
  output logic [1:0]           MemToReg,
  output logic                 halt,
  output logic [4:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  state_t                curState, nextState, decodeNext;
  logic [2:0]            decFunct, rFunctQ;
  logic                  haltQ;
  logic [INSTRET_W-1:0]  instretQ;
  logic                  retire;
  logic                  branchTaken;
  logic [6:0]            opcode, funct7;
  logic [2:0]            funct3;
  logic                  unusedInstBits;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  // Register and immediate fields belong to the datapath, not to control.
  assign unusedInstBits = ^{inst[24:15], inst[11:7]};

  // beq takes the branch on zero, bne on non-zero.
  assign branchTaken = zero ^ funct3[0];

  ctrl_decode uDecode (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .nextState(decodeNext),
    .rFunct   (decFunct)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      curState <= RST;
      haltQ    <= 1'b0;
      instretQ <= '0;
      rFunctQ  <= ALU_ADD;
    end else begin
      curState <= nextState;
      haltQ    <= (nextState == HALT);
      if (retire) instretQ <= instretQ + INSTRET_W'(1);
      // Latch the R-type operation so R_EXEC outputs depend on state alone.
      if (curState == DECODE) rFunctQ <= decFunct;
    end
  end

  always_comb begin
    nextState = curState;
    retire    = 1'b0;
    case (curState)
      RST:     nextState = FETCH;
      FETCH:   nextState = DECODE;
      DECODE:  nextState = decodeNext;
      R_EXEC:  nextState = R_WB;
      I_EXEC:  nextState = I_WB;
      LD_ADDR: nextState = LD_MEM;
      LD_MEM:  nextState = LD_MDR;
      LD_MDR:  nextState = LD_WB;
      SD_ADDR: nextState = SD_MEM;
      R_WB, I_WB, LD_WB, LUI_WB, SD_MEM, PC_INC: begin
        nextState = FETCH;
        retire    = 1'b1;
      end
      BRANCH: begin
        if (branchTaken) begin
          nextState = FETCH;
          retire    = 1'b1;
        end else begin
          nextState = PC_INC;
        end
      end
      HALT:    nextState = HALT;
      default: nextState = HALT;
    endcase
  end

  always_comb begin
    PCSrc       = 1'b0;
    ALUFunct    = ALU_NOP;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REGB;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchOp    = 1'b0;
    LoadRegA    = 1'b0;
    LoadRegB    = 1'b0;
    LoadALUOut  = 1'b0;
    LoadIR      = 1'b0;
    LoadMDR     = 1'b0;
    WriteReg    = 1'b0;
    IMemWrite   = 1'b0;
    DMemWrite   = 1'b0;
    MemToReg    = MTR_ALUOUT;
    case (curState)
      FETCH: LoadIR = 1'b1;
      DECODE: begin
        // Speculatively compute the branch target while the register file is read.
        LoadRegA   = 1'b1;
        LoadRegB   = 1'b1;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_IMMSH;
        ALUFunct   = ALU_ADD;
        LoadALUOut = 1'b1;
      end
      R_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REGB;
        ALUFunct   = rFunctQ;
        LoadALUOut = 1'b1;
      end
      I_EXEC, LD_ADDR, SD_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUFunct   = ALU_ADD;
        LoadALUOut = 1'b1;
      end
      LD_MDR: LoadMDR = 1'b1;
      R_WB, I_WB, LD_WB, LUI_WB, SD_MEM, PC_INC: begin
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_FOUR;
        ALUFunct  = ALU_ADD;
        PCSrc     = 1'b0;
        PCWrite   = 1'b1;
        WriteReg  = isSeqRetire(curState) && (curState != SD_MEM) && (curState != PC_INC);
        DMemWrite = (curState == SD_MEM);
        if (curState == LD_WB) MemToReg = MTR_MDR;
        else if (curState == LUI_WB) MemToReg = MTR_IMM;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_REGB;
        ALUFunct    = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = 1'b1;
        BranchOp    = funct3[0];
      end
      default: ;
    endcase
  end

  assign state   = curState;
  assign halt    = haltQ;
  assign instret = instretQ;

endmodule
